pc_fetch_ctrl: RTL and testbench

//   Program-counter stage: registers the next-PC value chosen by the 2:1/3:1 select path
//   and issues it as an instruction-memory request via a valid/ready handshake.

---
 rtl/pc_pkg.sv | 11 +
 rtl/pc_fetch_ctrl_if.sv | 23 ++
 rtl/pc_next_sel.sv | 36 +++
 rtl/pc_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the PC fetch stage
package pc_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_STEP     = 4;

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT} fetch_state_e;

    typedef enum logic [1:0] {SEQ, BR, JMP, PEND} redir_src_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction-memory request interface of the fetch stage
interface pc_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             imem_valid;
    logic             imem_ready;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] pc_next_seq;

    modport master (
        output imem_valid,
        output imem_addr,
        output pc_next_seq,
        input  imem_ready
    );

    modport slave (
        input  imem_valid,
        input  imem_addr,
        input  pc_next_seq,
        output imem_ready
    );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority select of the next PC: pending > jump > branch > sequential
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             pend_vld,
    input  logic [WIDTH-1:0] pend_tgt,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_tgt,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic [WIDTH-1:0] seq_pc,
    output logic [WIDTH-1:0] next_pc
);
    redir_src_e src;

    always_comb begin
        src = SEQ;
        if (pend_vld) begin
            src = PEND;
        end else if (jump) begin
            src = JMP;
        end else if (branch) begin
            src = BR;
        end

        next_pc = seq_pc;
        case (src)
            PEND:    next_pc = pend_tgt;
            JMP:     next_pc = jump_tgt;
            BR:      next_pc = branch_tgt;
            default: next_pc = seq_pc;
        endcase
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register and imem request handshake with one buffered redirect
// Optional PC_ALIGN_CHECK_EN: misaligned redirects are dropped and flagged on a sticky misalign output.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      STEP     = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_tgt,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    pc_fetch_ctrl_if.master  imem
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic             jump_ok, branch_ok, redir;
    logic [WIDTH-1:0] jump_t, branch_t, redir_tgt, seq_pc, sel_pc;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic jump_bad, branch_bad;

    assign jump_bad   = |(jump_tgt & ALIGN_MASK);
    assign branch_bad = |(branch_tgt & ALIGN_MASK);
    // A misaligned jump still shadows a same-cycle branch; both are lost.
    assign jump_ok    = jump & ~jump_bad;
    assign branch_ok  = branch & ~jump & ~branch_bad;
    assign jump_t     = jump_tgt;
    assign branch_t   = branch_tgt;
    assign misalign_d = misalign_q | (jump & jump_bad) | (branch & ~jump & branch_bad);
    assign misalign   = misalign_q;
`else
    assign jump_ok    = jump;
    assign branch_ok  = branch & ~jump;
    assign jump_t     = jump_tgt & ~ALIGN_MASK;
    assign branch_t   = branch_tgt & ~ALIGN_MASK;
`endif

    assign redir     = jump_ok | branch_ok;
    assign redir_tgt = jump_ok ? jump_t : branch_t;
    assign seq_pc    = pc_q + WIDTH'(STEP);

    assign imem.imem_addr   = pc_q;
    assign imem.pc_next_seq = seq_pc;

    pc_next_sel #(.WIDTH(WIDTH)) u_next_sel (
        .pend_vld   (pend_vld_q),
        .pend_tgt   (pend_tgt_q),
        .jump       (jump_ok),
        .jump_tgt   (jump_t),
        .branch     (branch_ok),
        .branch_tgt (branch_t),
        .seq_pc     (seq_pc),
        .next_pc    (sel_pc)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_vld_d      = pend_vld_q;
        pend_tgt_d      = pend_tgt_q;
        imem.imem_valid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = ISSUE;
                if (redir) pc_d = sel_pc;
            end
            ISSUE: begin
                imem.imem_valid = ~stall;
                if (stall) begin
                    if (redir) pc_d = sel_pc;
                end else if (imem.imem_ready) begin
                    pc_d = sel_pc;
                end else begin
                    state_d = WAIT;
                    if (redir) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = redir_tgt;
                    end
                end
            end
            WAIT: begin
                imem.imem_valid = 1'b1;
                if (imem.imem_ready) begin
                    state_d    = ISSUE;
                    pc_d       = sel_pc;
                    pend_vld_d = 1'b0;
                end else if (redir) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl (optionally with PC_ALIGN_CHECK_EN)
module tb_pc_fetch_ctrl;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_tgt = '0;
    logic [31:0] jump_tgt = '0;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    pc_fetch_ctrl_if #(.WIDTH(32)) imem ();

    pc_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch     (branch),
        .branch_tgt (branch_tgt),
        .jump       (jump),
        .jump_tgt   (jump_tgt),
`ifdef PC_ALIGN_CHECK_EN
        .misalign   (misalign),
`endif
        .imem       (imem)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        ev;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic s, input logic r, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic ev, input logic [31:0] ea);
        vec_t v;
        v.stall = s; v.ready = r; v.br = b; v.bt = bt; v.jp = j; v.jt = jt; v.ev = ev; v.ea = ea;
        tbl.push_back(v);
    endfunction

    // Reference model: PC, whether a request is outstanding, and a one-deep pending queue.
    logic [31:0] m_pc;
    bit          m_booted, m_out, m_mis;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_pc = 32'h0; m_booted = 0; m_out = 0; m_mis = 0;
        m_pend.delete();
    endtask

    function automatic bit model_valid();
        return m_booted && (m_out || !stall);
    endfunction

    task automatic model_step();
        bit          have = 0;
        logic [31:0] t = '0;
        bit          v;
        if (jump) begin
            if (ALIGN_CHK && jump_tgt[1:0] != 2'b00) m_mis = 1;
            else begin have = 1; t = jump_tgt & ~32'h3; end
        end else if (branch) begin
            if (ALIGN_CHK && branch_tgt[1:0] != 2'b00) m_mis = 1;
            else begin have = 1; t = branch_tgt & ~32'h3; end
        end
        v = model_valid();
        if (!m_booted) begin
            m_booted = 1;
            if (have) m_pc = t;
        end else if (v && imem.imem_ready) begin
            if (m_pend.size() != 0) m_pc = m_pend[0];
            else if (have)          m_pc = t;
            else                    m_pc = m_pc + 32'd4;
            m_pend.delete();
            m_out = 0;
        end else if (v) begin
            m_out = 1;
            if (have) begin m_pend.delete(); m_pend.push_back(t); end
        end else if (have) begin
            m_pc = t;
        end
    endtask

    initial begin
        logic [31:0] a9;
        a9 = ALIGN_CHK ? 32'h104 : 32'h100;
        //   stall ready br  bt            jp  jt            ev  ea
        add(0, 1, 0, 0,            0, 0,            0, 32'h0);
        add(0, 1, 0, 0,            0, 0,            1, 32'h0);
        add(0, 1, 0, 0,            0, 0,            1, 32'h4);
        add(0, 0, 0, 0,            0, 0,            1, 32'h8);
        add(1, 0, 1, 32'h40,       0, 0,            1, 32'h8);
        add(1, 0, 0, 0,            0, 0,            1, 32'h8);
        add(1, 1, 0, 0,            0, 0,            1, 32'h8);
        add(0, 1, 1, 32'h40,       1, 32'h100,      1, 32'h40);
        add(0, 1, 0, 0,            1, 32'h102,      1, 32'h100);
        add(0, 0, 0, 0,            0, 0,            1, a9);
        add(0, 1, 0, 0,            0, 0,            1, a9);
        add(1, 1, 0, 0,            0, 0,            0, a9 + 32'd4);
        add(1, 1, 1, 32'h200,      0, 0,            0, a9 + 32'd4);
        add(0, 1, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'h200);
        add(0, 1, 0, 0,            0, 0,            1, 32'hFFFF_FFFC);
        add(0, 1, 0, 0,            0, 0,            1, 32'h0);
        add(0, 0, 0, 0,            0, 0,            1, 32'h4);
        add(1, 0, 0, 0,            0, 0,            1, 32'h4);

        imem.imem_ready = 1'b0;
        #2 check("reset_valid", 32'(imem.imem_valid), 32'h0);
        check("reset_addr", imem.imem_addr, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            stall = tbl[i].stall; imem.imem_ready = tbl[i].ready;
            branch = tbl[i].br; branch_tgt = tbl[i].bt;
            jump = tbl[i].jp; jump_tgt = tbl[i].jt;
            #3;
            check($sformatf("vec%0d_valid", i), 32'(imem.imem_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_addr", i), imem.imem_addr, tbl[i].ea);
            check($sformatf("vec%0d_seq", i), imem.pc_next_seq, tbl[i].ea + 32'd4);
            @(posedge clk); #1;
        end
        stall = 0; branch = 0; jump = 0;
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_sticky", 32'(misalign), 32'h1);
`endif

        // Reset in the middle of an outstanding request.
        check("wait_before_rst", 32'(imem.imem_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1 check("rst_async_valid", 32'(imem.imem_valid), 32'h0);
        check("rst_async_addr", imem.imem_addr, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        check("rst_misalign", 32'(misalign), 32'h0);
`endif
        @(posedge clk); #1 rst_n = 1'b1; imem.imem_ready = 1'b1;
        #3 check("boot_valid", 32'(imem.imem_valid), 32'h0);
        @(posedge clk); #1;
        #3 check("post_boot_valid", 32'(imem.imem_valid), 32'h1);
        check("post_boot_addr", imem.imem_addr, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
        branch = 1'b1; branch_tgt = 32'h42;
        @(posedge clk); #1 branch = 1'b0;
        #3 check("mis_seq_addr", imem.imem_addr, 32'h4);
        check("mis_set", 32'(misalign), 32'h1);
        @(posedge clk); #1;
        #3 check("mis_hold", 32'(misalign), 32'h1);
`endif

        // Randomized run against the reference model.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            stall           = ($urandom_range(0, 9) < 3);
            imem.imem_ready = 1'($urandom_range(0, 1));
            jump            = ($urandom_range(0, 9) == 0);
            branch          = ($urandom_range(0, 6) == 0);
            jump_tgt        = ($urandom & ~32'h3) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            branch_tgt      = ($urandom & ~32'h3) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            if (i % 97 == 50) jump_tgt = 32'hFFFF_FFFC;
            #3;
            check($sformatf("rnd%0d_valid", i), 32'(imem.imem_valid), 32'(model_valid()));
            check($sformatf("rnd%0d_addr", i), imem.imem_addr, m_pc);
            check($sformatf("rnd%0d_seq", i), imem.pc_next_seq, m_pc + 32'd4);
`ifdef PC_ALIGN_CHECK_EN
            check($sformatf("rnd%0d_mis", i), 32'(misalign), 32'(m_mis));
`endif
            model_step();
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
